// File: rtl/bon_match_logger.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bon_match_logger : logs matcher hit addresses into a FIFO, counts matches,
//                    optional count check against the matcher result.
// Optional feature macro: BON_LOGGER_CHECK_EN
// Rev 1.0
// ----------------------------------------------------------------------------
module bon_match_logger #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 10,
  parameter int DEPTH  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              flag_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              fin_i,
  input  logic [CNT_W-1:0]  result_i,
  input  logic              rd_req_i,
  output logic [ADDR_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              overflow_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  match_cnt_o,
  output logic              mismatch_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]       occ_q, occ_d;
  logic              empty_q, empty_d, full_q, full_d;
  logic              ovf_q, ovf_d, rv_q, rv_d;
  logic [ADDR_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              active, clear, pop, push;

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    occ_d   = occ_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    rv_d    = 1'b0;

    // Logging only happens in RUN while start is still held.
    active  = (state_q == RUN) && start_i;
    clear   = (state_q == IDLE) && start_i;
    pop     = rd_req_i && !empty_q;
    push    = active && flag_i && (!full_q || pop);
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN: begin
        if (!start_i)   state_d = IDLE;
        else if (fin_i) state_d = DONE;
      end
      DONE:    if (!start_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (pop) begin
      rv_d    = 1'b1;
      rdata_d = mem_q[rptr_q];
      rptr_d  = rptr_q + 1'b1;
    end
    if (push) wptr_d = wptr_q + 1'b1;

    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    if (active && flag_i) begin
      cnt_d = cnt_inc;
      if (!push) ovf_d = 1'b1;
    end

    if (clear) begin
      wptr_d = '0;
      rptr_d = '0;
      occ_d  = '0;
      cnt_d  = '0;
      ovf_d  = 1'b0;
    end

    empty_d = (occ_d == '0);
    full_d  = (occ_d == (AW+1)'(DEPTH));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      occ_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      occ_q   <= occ_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      rv_q    <= rv_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= addr_i;
  end

`ifdef BON_LOGGER_CHECK_EN
  logic mm_q, mm_d;

  // The compare uses the count including a flag in the fin cycle.
  always_comb begin
    mm_d = mm_q;
    if (active && fin_i)
      mm_d = ((flag_i ? cnt_inc : cnt_q) != result_i);
    if (clear) mm_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) mm_q <= 1'b0;
    else         mm_q <= mm_d;
  end

  assign mismatch_o = mm_q;
`else
  logic unused_result;
  assign unused_result = ^result_i;
  assign mismatch_o    = 1'b0;
`endif

  assign rd_data_o   = rdata_q;
  assign rd_valid_o  = rv_q;
  assign empty_o     = empty_q;
  assign full_o      = full_q;
  assign overflow_o  = ovf_q;
  assign done_o      = (state_q == DONE);
  assign match_cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_bon_match_logger.sv
`default_nettype none
// Testbench for bon_match_logger: fixed vector table, directed sequences and
// randomized scans checked against a queue-based reference model.
module tb_bon_match_logger;
  localparam int ADDR_W = 10;
  localparam int CNT_W  = 10;
  localparam int DEPTH  = 16;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0, flag = 1'b0, fin = 1'b0, rd_req = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [CNT_W-1:0]  result = '0;
  logic [ADDR_W-1:0] rd_data;
  logic              rd_valid, empty, full, overflow, done, mismatch;
  logic [CNT_W-1:0]  match_cnt;

  int total = 0;
  int bad   = 0;

  bon_match_logger #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .flag_i(flag),
    .addr_i(addr), .fin_i(fin), .result_i(result), .rd_req_i(rd_req),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid), .empty_o(empty),
    .full_o(full), .overflow_o(overflow), .done_o(done),
    .match_cnt_o(match_cnt), .mismatch_o(mismatch)
  );

  always #5 clk = ~clk;

`ifdef BON_LOGGER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  // Reference model: mode 0 = waiting, 1 = scanning, 2 = finished.
  int m_q[$];
  int m_cnt, m_rd, m_mode;
  bit m_ovf, m_mm, m_rv;

  task automatic model_reset();
    m_q.delete();
    m_cnt = 0; m_rd = 0; m_mode = 0;
    m_ovf = 0; m_mm = 0; m_rv = 0;
  endtask

  task automatic model_update(input bit st, input bit fl, input int ad,
                              input bit fn, input int res, input bit rd);
    if (rd && m_q.size() > 0) begin
      m_rd = m_q.pop_front();
      m_rv = 1;
    end else m_rv = 0;
    if (m_mode == 0) begin
      if (st) begin
        m_q.delete(); m_cnt = 0; m_ovf = 0; m_mm = 0; m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (!st) m_mode = 0;
      else begin
        if (fl) begin
          m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
          if (m_q.size() < DEPTH) m_q.push_back(ad);
          else m_ovf = 1;
        end
        if (fn) begin
          if (CHK) m_mm = (m_cnt != res);
          m_mode = 2;
        end
      end
    end else if (!st) m_mode = 0;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("done",      int'(done),      int'(m_mode == 2));
    check("match_cnt", int'(match_cnt), m_cnt);
    check("empty",     int'(empty),     int'(m_q.size() == 0));
    check("full",      int'(full),      int'(m_q.size() == DEPTH));
    check("overflow",  int'(overflow),  int'(m_ovf));
    check("rd_valid",  int'(rd_valid),  int'(m_rv));
    check("rd_data",   int'(rd_data),   m_rd);
    check("mismatch",  int'(mismatch),  int'(m_mm));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_done"},     int'(done),      0);
    check({tag, "_cnt"},      int'(match_cnt), 0);
    check({tag, "_empty"},    int'(empty),     1);
    check({tag, "_full"},     int'(full),      0);
    check({tag, "_overflow"}, int'(overflow),  0);
    check({tag, "_rd_valid"}, int'(rd_valid),  0);
    check({tag, "_rd_data"},  int'(rd_data),   0);
    check({tag, "_mismatch"}, int'(mismatch),  0);
  endtask

  task automatic step(input bit st, input bit fl, input int ad, input bit fn,
                      input int res, input bit rd);
    start = st; flag = fl; addr = ADDR_W'(ad); fin = fn;
    result = CNT_W'(res); rd_req = rd;
    @(posedge clk);
    model_update(st, fl, ad, fn, res, rd);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    start = 0; flag = 0; fin = 0; rd_req = 0; addr = '0; result = '0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    model_reset();
    rst_n = 1;
  endtask

  task automatic new_scan();
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0);
  endtask

  typedef struct {
    bit st, fl; int ad; bit fn; int res; bit rd;
    bit e_done; int e_cnt; bit e_empty, e_full, e_ovf, e_rv; int e_rd;
  } vec_t;

  vec_t vt[12];

  initial begin
    // inputs: st fl ad fn res rd | done cnt empty full ovf rv rd_data
    vt[0]  = '{1,1, 3,1,0,0, 0,0,1,0,0,0, 0};
    vt[1]  = '{1,0, 0,0,0,0, 0,0,1,0,0,0, 0};
    vt[2]  = '{1,1, 7,0,0,0, 0,1,0,0,0,0, 0};
    vt[3]  = '{1,1, 9,0,0,1, 0,2,0,0,0,1, 7};
    vt[4]  = '{1,0, 0,0,0,1, 0,2,1,0,0,1, 9};
    vt[5]  = '{1,0, 0,0,0,1, 0,2,1,0,0,0, 9};
    vt[6]  = '{1,1,12,0,0,1, 0,3,0,0,0,0, 9};
    vt[7]  = '{1,1,13,1,4,0, 1,4,0,0,0,0, 9};
    vt[8]  = '{1,1,20,1,0,0, 1,4,0,0,0,0, 9};
    vt[9]  = '{0,0, 0,0,0,1, 0,4,0,0,0,1,12};
    vt[10] = '{0,0, 0,0,0,1, 0,4,1,0,0,1,13};
    vt[11] = '{0,0, 0,0,0,0, 0,4,1,0,0,0,13};

    do_reset();

    for (int i = 0; i < 12; i++) begin
      step(vt[i].st, vt[i].fl, vt[i].ad, vt[i].fn, vt[i].res, vt[i].rd);
      check($sformatf("vec%0d_done", i),  int'(done),      int'(vt[i].e_done));
      check($sformatf("vec%0d_cnt", i),   int'(match_cnt), vt[i].e_cnt);
      check($sformatf("vec%0d_empty", i), int'(empty),     int'(vt[i].e_empty));
      check($sformatf("vec%0d_full", i),  int'(full),      int'(vt[i].e_full));
      check($sformatf("vec%0d_ovf", i),   int'(overflow),  int'(vt[i].e_ovf));
      check($sformatf("vec%0d_rv", i),    int'(rd_valid),  int'(vt[i].e_rv));
      check($sformatf("vec%0d_rdata", i), int'(rd_data),   vt[i].e_rd);
    end

    // Full 1024-word scan with three hits.
    new_scan();
    for (int a = 0; a < 1024; a++)
      step(1, (a == 5 || a == 17 || a == 900), a, 0, 0, 0);
    step(1, 0, 0, 1, 3, 0);
    check("scan_done", int'(done), 1);
    check("scan_cnt", int'(match_cnt), 3);
    check("scan_empty", int'(empty), 0);
    check("scan_mm", int'(mismatch), 0);
    step(1, 0, 0, 0, 0, 1); check("pop0", int'(rd_data), 5);
    step(1, 0, 0, 0, 0, 1); check("pop1", int'(rd_data), 17);
    step(1, 0, 0, 0, 0, 1); check("pop2", int'(rd_data), 900);
    check("pop2_rv", int'(rd_valid), 1);
    check("pop2_empty", int'(empty), 1);

    // Spurious fin in the start cycle, then a clean scan.
    new_scan();
    check("quirk_notdone", int'(done), 0);
    for (int a = 0; a < 40; a++) step(1, 0, a, 0, 0, 0);
    check("quirk_still_run", int'(done), 0);
    step(1, 0, 0, 1, 0, 0);
    check("clean_done", int'(done), 1);
    check("clean_cnt", int'(match_cnt), 0);
    check("clean_empty", int'(empty), 1);

    // Overflow: 20 flags, no reads.
    new_scan();
    for (int a = 0; a < 20; a++) step(1, 1, a, 0, 0, 0);
    step(1, 0, 0, 1, 20, 0);
    check("ovf_full", int'(full), 1);
    check("ovf_sticky", int'(overflow), 1);
    check("ovf_cnt", int'(match_cnt), 20);
    for (int a = 0; a < 16; a++) begin
      step(1, 0, 0, 0, 0, 1);
      check($sformatf("ovf_pop%0d", a), int'(rd_data), a);
    end
    check("ovf_drained", int'(empty), 1);

    // Full FIFO with simultaneous push and pop.
    new_scan();
    for (int a = 40; a < 56; a++) step(1, 1, a, 0, 0, 0);
    step(1, 1, 99, 0, 0, 1);
    check("fullpp_rd", int'(rd_data), 40);
    check("fullpp_full", int'(full), 1);
    check("fullpp_ovf", int'(overflow), 0);
    step(1, 0, 0, 1, 17, 0);
    for (int a = 0; a < 16; a++) step(1, 0, 0, 0, 0, 1);
    check("fullpp_last", int'(rd_data), 99);

    // Count check: 4 flags, the last on fin, result 4 then 3.
    for (int r = 4; r >= 3; r--) begin
      new_scan();
      step(1, 1, 2, 0, 0, 0);
      step(1, 1, 4, 0, 0, 0);
      step(1, 1, 6, 0, 0, 0);
      step(1, 1, 8, 1, r, 0);
      check($sformatf("mm_res%0d", r), int'(mismatch), int'(CHK && r == 3));
      check($sformatf("mm_cnt%0d", r), int'(match_cnt), 4);
    end

    // Counter saturation.
    new_scan();
    for (int a = 0; a < 1030; a++) step(1, 1, a % 1024, 0, 0, (a % 3) == 0);
    check("sat_cnt", int'(match_cnt), CMAX);
    step(1, 0, 0, 1, CMAX, 0);

    // Randomized scans, with occasional aborts.
    for (int s = 0; s < 6; s++) begin
      int n, ab;
      step(0, 0, 0, 0, 0, $urandom_range(0, 1));
      step(1, $urandom_range(0, 1), 0, $urandom_range(0, 1), 0, $urandom_range(0, 1));
      n  = $urandom_range(60, 250);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(5, n - 1) : -1;
      for (int a = 0; a < n; a++) begin
        if (a == ab) begin
          step(0, 0, a, 0, 0, $urandom_range(0, 1));
          break;
        end
        step(1, $urandom_range(0, 3) == 0, a, 0, 0, $urandom_range(0, 2) == 0);
      end
      if (ab < 0)
        step(1, $urandom_range(0, 1), n, 1,
             ($urandom_range(0, 1) != 0) ? m_cnt + 1 : int'($urandom_range(0, CMAX)), 0);
      for (int k = 0; k < 4; k++) step(start, 0, 0, 0, 0, $urandom_range(0, 1));
    end

    // Asynchronous reset mid-scan after two flags.
    new_scan();
    step(1, 1, 3, 0, 0, 0);
    step(1, 1, 8, 0, 0, 0);
    #2;
    rst_n = 0;
    #1;
    check_reset_vals("async");
    model_reset();
    start = 0; flag = 0; fin = 0; rd_req = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    step(1, 1, 1, 1, 0, 0);
    check("post_rst_idle", int'(done), 0);
    check("post_rst_cnt", int'(match_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
`default_nettype wire
